// File: rtl/bus_rd_fifo_pkg.sv
// bus_rd_fifo_pkg: shared definitions for the buffered bus read port.
//   - output-register state encoding (IDLE / FETCH / HOLD)
//   - bit positions of the fields inside the 32-bit status word
package bus_rd_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // output register empty
    S_FETCH = 2'd1,  // RAM read in flight
    S_HOLD  = 2'd2   // output register holds the head word
  } state_e;

  localparam int ST_COUNT_LSB = 0;   // [15:0]  occupancy
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVF       = 18;  // sticky: write rejected while full
  localparam int ST_UNF       = 19;  // sticky: pop while head not valid
  localparam int ST_LOST_LSB  = 24;  // [31:24] rejected-write counter

  localparam logic [31:0] STATUS_RST = 32'h0001_0000;

endpackage

// File: rtl/bus_rd_fifo_ram_sdp.sv
// ram_sdp: simple dual-port RAM, one write port and one synchronous read
// port with one cycle of read latency. Read and write in the same cycle
// to the same address return the old contents.
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request; rdata valid on the following cycle
module ram_sdp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 511,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_rd_fifo.sv
// bus_rd_fifo: queues producer words and presents the head word to a
// read-only bus register. Storage is a RAM of DEPTH-1 entries plus a
// one-entry output register holding the head word.
//   bus_clk, bus_reset   clock, synchronous active-high reset
//   wr_data, wr_en       producer write, one word per cycle
//   rd_pulse             pop strobe from the data register
//   stat_rd_pulse        status register strobe; clears sticky flags
//   rd_data              head word (0 when empty)
//   status               {lost[7:0], 4'b0, unf, ovf, full, empty, count[15:0]}
//   not_empty            head word valid (interrupt source)
// Optional feature: define BUS_RD_FIFO_LOST_CNT_EN to build the saturating
// rejected-write counter reported in status[31:24].
module bus_rd_fifo
  import bus_rd_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 512
) (
  input  logic                 bus_clk,
  input  logic                 bus_reset,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 wr_en,
  input  logic                 rd_pulse,
  input  logic                 stat_rd_pulse,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic [31:0]          status,
  output logic                 not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 2);

  state_e               state_q, state_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]        ram_cnt_q, ram_cnt_d;   // words held in the RAM
  logic [DATAWIDTH-1:0] out_q, out_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]          status_q, status_d;
  logic [7:0]           lost;

  logic [CW-1:0]        count;
  logic                 ram_empty, accept_wr, pop, bypass;
  logic                 ram_we, ram_re, ovf_ev, unf_ev;
  logic [DATAWIDTH-1:0] ram_rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // In FETCH the word in flight has already left the RAM but still counts
  // as occupying the output register.
  assign count     = {1'b0, ram_cnt_q} + CW'(state_q != S_IDLE);
  assign ram_empty = (ram_cnt_q == '0);
  // A pop in the same cycle does not free space for the write.
  assign accept_wr = wr_en && (count < CW'(DEPTH));
  assign pop       = rd_pulse && (state_q == S_HOLD);
  assign ovf_ev    = wr_en && !accept_wr;
  assign unf_ev    = rd_pulse && (state_q != S_HOLD);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    bypass  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A non-empty RAM while idle is drained regardless of writes.
        if (!ram_empty) begin
          ram_re  = 1'b1;
          state_d = S_FETCH;
        end else if (accept_wr) begin
          bypass  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pop) begin
          if (!ram_empty) begin
            ram_re  = 1'b1;
            state_d = S_FETCH;
          end else if (accept_wr) begin
            bypass = 1'b1;
          end else begin
            state_d = S_IDLE;
            out_d   = '0;
          end
        end
      end
      S_FETCH: begin
        state_d = S_HOLD;
        out_d   = ram_rdata;
      end
      default: state_d = S_IDLE;
    endcase
    if (bypass) out_d = wr_data;
  end

  assign ram_we    = accept_wr && !bypass;
  assign wptr_d    = ram_we ? ptr_inc(wptr_q) : wptr_q;
  assign rptr_d    = ram_re ? ptr_inc(rptr_q) : rptr_q;
  assign ram_cnt_d = ram_cnt_q + AW'(ram_we) - AW'(ram_re);

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  assign ovf_d = ovf_ev ? 1'b1 : (stat_rd_pulse ? 1'b0 : ovf_q);
  assign unf_d = unf_ev ? 1'b1 : (stat_rd_pulse ? 1'b0 : unf_q);

`ifdef BUS_RD_FIFO_LOST_CNT_EN
  logic [7:0] lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if (ovf_ev) begin
      if (stat_rd_pulse)          lost_d = 8'd1;
      else if (lost_q != 8'hFF)   lost_d = lost_q + 8'd1;
    end else if (stat_rd_pulse) begin
      lost_d = '0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) lost_q <= '0;
    else           lost_q <= lost_d;
  end

  assign lost = lost_q;
`else
  assign lost = '0;
`endif

  always_comb begin
    status_d = '0;
    status_d[ST_COUNT_LSB +: 16] = 16'(count);
    status_d[ST_EMPTY]           = (count == '0);
    status_d[ST_FULL]            = (count == CW'(DEPTH));
    status_d[ST_OVF]             = ovf_q;
    status_d[ST_UNF]             = unf_q;
    status_d[ST_LOST_LSB +: 8]   = lost;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      status_q  <= STATUS_RST;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      status_q  <= status_d;
    end
  end

  ram_sdp #(
    .WIDTH (DATAWIDTH),
    .DEPTH (DEPTH - 1),
    .AW    (AW)
  ) u_ram (
    .clk   (bus_clk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  assign rd_data   = out_q;
  assign status    = status_q;
  assign not_empty = (state_q == S_HOLD);

endmodule

// File: tb/tb_bus_rd_fifo.sv
// Directed bench for bus_rd_fifo: a DEPTH=4 instance driven by a vector
// table, plus a DEPTH=8 instance used for a long streaming sequence.
module tb_bus_rd_fifo;

  logic       clk = 1'b0;
  logic       bus_reset, wr_en, rd_pulse, stat_rd_pulse;
  logic [7:0] wr_data;
  logic [7:0] rd4, rd8;
  logic [31:0] st4, st8;
  logic       ne4, ne8;

  int checks = 0;
  int fails  = 0;

`ifdef BUS_RD_FIFO_LOST_CNT_EN
  localparam logic [31:0] L1 = 32'h0100_0000;
`else
  localparam logic [31:0] L1 = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  bus_rd_fifo #(.DATAWIDTH(8), .DEPTH(4)) u4 (
    .bus_clk(clk), .bus_reset(bus_reset), .wr_data(wr_data), .wr_en(wr_en),
    .rd_pulse(rd_pulse), .stat_rd_pulse(stat_rd_pulse),
    .rd_data(rd4), .status(st4), .not_empty(ne4)
  );

  bus_rd_fifo #(.DATAWIDTH(8), .DEPTH(8)) u8 (
    .bus_clk(clk), .bus_reset(bus_reset), .wr_data(wr_data), .wr_en(wr_en),
    .rd_pulse(rd_pulse), .stat_rd_pulse(stat_rd_pulse),
    .rd_data(rd8), .status(st8), .not_empty(ne8)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        rp;
    logic        sp;
    logic [7:0]  exp_rd;
    logic        exp_ne;
    logic        chk_st;
    logic [31:0] exp_st;
  } vec_t;

  vec_t tbl[41];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, sample #1 after it, return inputs to idle.
  task automatic step(input logic we, input logic [7:0] wd, input logic rp, input logic sp);
    wr_en = we; wr_data = wd; rd_pulse = rp; stat_rd_pulse = sp;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_data = '0; rd_pulse = 1'b0; stat_rd_pulse = 1'b0;
  endtask

  task automatic do_reset();
    bus_reset = 1'b1;
    @(posedge clk); #1;
    bus_reset = 1'b0;
  endtask

  task automatic setv(input int i, input logic we, input logic [7:0] wd, input logic rp,
                      input logic sp, input logic [7:0] erd, input logic ene,
                      input logic cst, input logic [31:0] est);
    tbl[i] = '{we, wd, rp, sp, erd, ene, cst, est};
  endtask

  initial begin
    logic [7:0] q[$];
    int sent, got, k, sz;
    bit rp_n, we_n;

    bus_reset = 1'b1; wr_en = 1'b0; rd_pulse = 1'b0; stat_rd_pulse = 1'b0; wr_data = '0;

    //      i  we wd     rp sp  rd     ne  cst status
    setv( 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0001_0000);
    setv( 1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);              // pop while empty
    setv( 2, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0009_0000);
    setv( 3, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);              // clear flags
    setv( 4, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0001_0000);
    setv( 5, 1, 8'hA5, 0, 0, 8'hA5, 1, 0, 0);              // bypass to head
    setv( 6, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);              // pop last word
    setv( 7, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0001_0000);
    setv( 8, 1, 8'h01, 0, 0, 8'h01, 1, 0, 0);
    setv( 9, 1, 8'h02, 0, 0, 8'h01, 1, 0, 0);
    setv(10, 1, 8'h03, 0, 0, 8'h01, 1, 0, 0);
    setv(11, 1, 8'h04, 0, 0, 8'h01, 1, 0, 0);
    setv(12, 1, 8'h05, 0, 0, 8'h01, 1, 0, 0);              // rejected
    setv(13, 0, 8'h00, 0, 0, 8'h01, 1, 1, 32'h0006_0004 | L1);
    setv(14, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0);              // FETCH, old word
    setv(15, 0, 8'h00, 0, 0, 8'h02, 1, 0, 0);
    setv(16, 0, 8'h00, 1, 0, 8'h02, 0, 0, 0);
    setv(17, 0, 8'h00, 0, 0, 8'h03, 1, 0, 0);
    setv(18, 0, 8'h00, 1, 0, 8'h03, 0, 0, 0);
    setv(19, 0, 8'h00, 0, 0, 8'h04, 1, 0, 0);
    setv(20, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    setv(21, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0005_0000 | L1);
    setv(22, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
    setv(23, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0001_0000);
    setv(24, 1, 8'h11, 0, 0, 8'h11, 1, 0, 0);
    setv(25, 1, 8'h22, 0, 0, 8'h11, 1, 0, 0);
    setv(26, 1, 8'h33, 0, 0, 8'h11, 1, 0, 0);
    setv(27, 1, 8'h44, 0, 0, 8'h11, 1, 0, 0);
    setv(28, 1, 8'h55, 1, 0, 8'h11, 0, 0, 0);              // full: write+pop
    setv(29, 0, 8'h00, 0, 0, 8'h22, 1, 1, 32'h0004_0003 | L1);
    setv(30, 1, 8'h66, 0, 0, 8'h22, 1, 0, 0);
    setv(31, 1, 8'h77, 0, 1, 8'h22, 1, 0, 0);              // reject + clear
    setv(32, 0, 8'h00, 0, 0, 8'h22, 1, 1, 32'h0006_0004 | L1);
    setv(33, 0, 8'h00, 1, 0, 8'h22, 0, 0, 0);
    setv(34, 0, 8'h00, 0, 0, 8'h33, 1, 0, 0);
    setv(35, 0, 8'h00, 1, 0, 8'h33, 0, 0, 0);
    setv(36, 0, 8'h00, 0, 0, 8'h44, 1, 0, 0);
    setv(37, 0, 8'h00, 1, 0, 8'h44, 0, 0, 0);
    setv(38, 0, 8'h00, 0, 0, 8'h66, 1, 0, 0);
    setv(39, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    setv(40, 0, 8'h00, 0, 0, 8'h00, 0, 1, 32'h0005_0000 | L1);

    repeat (2) @(posedge clk);
    #1;
    bus_reset = 1'b0;
    chk("reset rd_data", {24'b0, rd4}, 32'h0);
    chk("reset not_empty", {31'b0, ne4}, 32'h0);

    for (int i = 0; i < 41; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].rp, tbl[i].sp);
      chk($sformatf("vec%0d rd_data", i), {24'b0, rd4}, {24'b0, tbl[i].exp_rd});
      chk($sformatf("vec%0d not_empty", i), {31'b0, ne4}, {31'b0, tbl[i].exp_ne});
      if (tbl[i].chk_st) chk($sformatf("vec%0d status", i), st4, tbl[i].exp_st);
    end

    // Reset with data queued returns outputs to reset values on that edge.
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    do_reset();
    chk("midreset rd_data", {24'b0, rd4}, 32'h0);
    chk("midreset not_empty", {31'b0, ne4}, 32'h0);
    chk("midreset status", st4, 32'h0001_0000);
    step(1'b1, 8'h9E, 1'b0, 1'b0);
    chk("post-reset first word", {24'b0, rd4}, 32'h0000_009E);

    // Streaming through the DEPTH=8 instance across many pointer wraps.
    do_reset();
    sent = 0; got = 0; k = 0;
    while (got < 1000 && k < 20000) begin
      sz   = q.size();
      rp_n = ne8 && (k % 3 != 1);
      if (rp_n) begin
        if (sz == 0) begin
          chk("stream unexpected head", {24'b0, rd8}, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("stream word %0d", got), {24'b0, rd8}, {24'b0, q[0]});
          void'(q.pop_front());
        end
        got++;
      end
      we_n = (sent < 1000) && (sz < 8) && (k % 5 != 4);
      if (we_n) begin
        q.push_back(8'(sent * 7 + 3));
        sent++;
      end
      step(we_n, we_n ? 8'(sent * 7 - 4) : 8'h00, rp_n, 1'b0);
      k++;
    end
    chk("stream words received", got, 1000);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stream final status", st8, 32'h0001_0000);
    chk("stream final not_empty", {31'b0, ne8}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
